// File: rtl/uart_fifo_if.sv
// Register-bank side of the buffered UART: configuration, FIFO strobes and status.
// The register bank is the master; the UART core is the slave.
interface uart_fifo_if #(
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DIVIDER_WIDTH   = 16
);
  logic                       uartEnable;
  logic [DIVIDER_WIDTH-1:0]   clockDivider;
  logic                       parityEnable;
  logic                       parityOdd;
  logic                       twoStopBits;
  logic                       txWriteEnable;
  logic [DATA_BITS-1:0]       txWriteData;
  logic                       txFull;
  logic                       txEmpty;
  logic                       txBusy;
  logic                       rxReadEnable;
  logic [DATA_BITS-1:0]       rxData;
  logic                       rxEmpty;
  logic [FIFO_DEPTH_LOG2:0]   rxCount;
  logic                       clearErrors;
  logic                       rxOverflow;
  logic                       frameError;
  logic                       parityError;

  modport master (
    output uartEnable, clockDivider, parityEnable, parityOdd, twoStopBits,
           txWriteEnable, txWriteData, rxReadEnable, clearErrors,
    input  txFull, txEmpty, txBusy, rxData, rxEmpty, rxCount,
           rxOverflow, frameError, parityError
  );

  modport slave (
    input  uartEnable, clockDivider, parityEnable, parityOdd, twoStopBits,
           txWriteEnable, txWriteData, rxReadEnable, clearErrors,
    output txFull, txEmpty, txBusy, rxData, rxEmpty, rxCount,
           rxOverflow, frameError, parityError
  );
endinterface

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with TX/RX circular FIFOs, programmable bit period,
// optional parity, 1/2 stop bits and sticky receive error flags.
module uart_fifo_buf #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [AW:0]  count
);
  localparam int DEPTH = 1 << AW;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, do_push, do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is still accepted when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_fifo_transceiver #(
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DIVIDER_WIDTH   = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_fifo_if.slave bus,
  output logic     uart_tx,
  input  logic     uart_rx
);
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [DIVIDER_WIDTH-1:0] clamp_div(input logic [DIVIDER_WIDTH-1:0] d);
    return (d < DIVIDER_WIDTH'(3)) ? DIVIDER_WIDTH'(3) : d;
  endfunction

  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 tx_empty, rx_full;

  state_t                   tx_state, tx_next;
  logic [DIVIDER_WIDTH-1:0] tx_div, tx_cnt;
  logic [BIT_W-1:0]         tx_bit;
  logic [DATA_BITS-1:0]     tx_shift;
  logic                     tx_par, tx_done, tx_last_data, tx_last_stop, tx_pop, tx_line;

  state_t                   rx_state, rx_next;
  logic [DIVIDER_WIDTH-1:0] rx_div, rx_cnt;
  logic [BIT_W-1:0]         rx_bit;
  logic [DATA_BITS-1:0]     rx_shift;
  logic                     rx_s1, rx_s2, rx_s3, rx_par, rx_fall, rx_done, rx_mid, rx_last_data;
  logic                     rx_push, set_ovf, set_frame, set_par;

  uart_fifo_buf #(.W(DATA_BITS), .AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(bus.txWriteEnable), .pop(tx_pop),
    .wdata(bus.txWriteData), .head(tx_head), .count(tx_count)
  );

  uart_fifo_buf #(.W(DATA_BITS), .AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(bus.rxReadEnable),
    .wdata(rx_shift), .head(rx_head), .count(rx_count)
  );

  assign tx_empty    = tx_count == '0;
  assign rx_full     = rx_count == CW'(DEPTH);
  assign bus.txEmpty = tx_empty;
  assign bus.txFull  = tx_count == CW'(DEPTH);
  assign bus.txBusy  = tx_state != IDLE;
  assign bus.rxData  = rx_head;
  assign bus.rxEmpty = rx_count == '0;
  assign bus.rxCount = rx_count;

  // ---- TX FSM ----
  assign tx_done      = tx_cnt == tx_div;
  assign tx_last_data = tx_bit == BIT_W'(DATA_BITS-1);
  assign tx_last_stop = !bus.twoStopBits || tx_bit == BIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (!tx_empty) tx_next = START;
      START:   if (tx_done) tx_next = DATA;
      DATA:    if (tx_done && tx_last_data) tx_next = bus.parityEnable ? PARITY : STOP;
      PARITY:  if (tx_done) tx_next = STOP;
      STOP:    if (tx_done && tx_last_stop) tx_next = tx_empty ? IDLE : START;
      default: tx_next = IDLE;
    endcase
    if (!bus.uartEnable) tx_next = IDLE;
  end

  // The last stop cycle chains straight into the next START, so frames abut.
  always_comb begin
    tx_pop = bus.uartEnable && !tx_empty &&
             (tx_state == IDLE || (tx_state == STOP && tx_done && tx_last_stop));
    case (tx_state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = tx_shift[0];
      PARITY:  tx_line = tx_par;
      default: tx_line = 1'b1;
    endcase
    if (!bus.uartEnable) tx_line = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) uart_tx <= 1'b1;
    else     uart_tx <= tx_line;
  end

  always_ff @(posedge clk) begin
    if (rst || tx_state == IDLE || tx_done) tx_cnt <= '0;
    else                                    tx_cnt <= tx_cnt + 1'b1;
    if (rst || tx_state == IDLE) tx_bit <= '0;
    else if (tx_done) begin
      if ((tx_state == DATA && !tx_last_data) || (tx_state == STOP && !tx_last_stop))
        tx_bit <= tx_bit + 1'b1;
      else
        tx_bit <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift <= tx_head;
      tx_div   <= clamp_div(bus.clockDivider);
      tx_par   <= ^tx_head ^ bus.parityOdd;
    end else if (tx_state == DATA && tx_done) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // ---- RX synchroniser and FSM ----
  always_ff @(posedge clk) begin
    if (rst) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else     {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
  end

  assign rx_fall      = rx_s3 && !rx_s2;
  assign rx_done      = rx_cnt == rx_div;
  assign rx_mid       = rx_cnt == (rx_div >> 1);
  assign rx_last_data = rx_bit == BIT_W'(DATA_BITS-1);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_next = START;
      START:   if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
      DATA:    if (rx_done && rx_last_data) rx_next = bus.parityEnable ? PARITY : STOP;
      PARITY:  if (rx_done) rx_next = STOP;
      STOP:    if (rx_done) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
    if (!bus.uartEnable) rx_next = IDLE;
  end

  always_comb begin
    rx_push   = bus.uartEnable && rx_state == STOP && rx_done;
    set_frame = rx_push && !rx_s2;
    set_par   = rx_push && bus.parityEnable && ((^rx_shift ^ bus.parityOdd) != rx_par);
    set_ovf   = rx_push && rx_full && !bus.rxReadEnable;
  end

  always_ff @(posedge clk) begin
    if (rst || rx_state == IDLE || (rx_state == START && rx_mid) || rx_done) rx_cnt <= '0;
    else                                                                   rx_cnt <= rx_cnt + 1'b1;
    if (rst || rx_state != DATA) rx_bit <= '0;
    else if (rx_done)            rx_bit <= rx_last_data ? '0 : rx_bit + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rx_state == IDLE && rx_fall) rx_div <= clamp_div(bus.clockDivider);
    if (rx_state == DATA && rx_done) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
    if (rx_state == PARITY && rx_done) rx_par <= rx_s2;
  end

  // Sticky flags: a set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rxOverflow  <= 1'b0;
      bus.frameError  <= 1'b0;
      bus.parityError <= 1'b0;
    end else begin
      bus.rxOverflow  <= set_ovf   || (bus.rxOverflow  && !bus.clearErrors);
      bus.frameError  <= set_frame || (bus.frameError  && !bus.clearErrors);
      bus.parityError <= set_par   || (bus.parityError && !bus.clearErrors);
    end
  end
endmodule
